// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, req/valid fetch FSM,
// one-entry skid buffer and redirect handling for the decoder.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_plus4,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;
    logic        skid_full;

    logic        consume;
    logic        slot_free;
    logic [31:0] target;
    logic [31:0] pc_next4;
    logic [31:0] addr_next4;
    logic        unused_bits;

    assign consume     = instr_valid && !stall;
    assign slot_free   = !instr_valid || !stall;
    assign target      = {redirect_pc[31:2], 2'b00};
    assign pc_next4    = pc + 32'd4;
    assign addr_next4  = imem_addr + 32'd4;
    assign opcode      = instr[31:26];
    assign unused_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            pc          <= RESET_PC;
            instr       <= '0;
            pc_plus4    <= '0;
            instr_valid <= 1'b0;
            skid_instr  <= '0;
            skid_pc4    <= '0;
            skid_full   <= 1'b0;
        end else if (redirect) begin
            pc          <= target;
            instr_valid <= 1'b0;
            skid_full   <= 1'b0;
            unique case (state)
                REQ: begin
                    // An un-answered request cannot be withdrawn.
                    if (imem_valid) begin
                        imem_addr <= target;
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                end
                default: begin
                    imem_addr <= target;
                    imem_req  <= 1'b1;
                    state     <= REQ;
                end
            endcase
        end else begin
            if (consume) begin
                instr_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    imem_addr <= pc;
                    imem_req  <= 1'b1;
                    state     <= REQ;
                end
                REQ: begin
                    if (imem_valid) begin
                        pc <= pc_next4;
                        if (slot_free) begin
                            instr       <= imem_rdata;
                            pc_plus4    <= addr_next4;
                            instr_valid <= 1'b1;
                            imem_addr   <= pc_next4;
                        end else begin
                            skid_instr <= imem_rdata;
                            skid_pc4   <= addr_next4;
                            skid_full  <= 1'b1;
                            imem_req   <= 1'b0;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (consume && skid_full) begin
                        instr       <= skid_instr;
                        pc_plus4    <= skid_pc4;
                        instr_valid <= 1'b1;
                        skid_full   <= 1'b0;
                        imem_addr   <= pc;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem_valid) begin
                        imem_addr <= pc;
                        state     <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the single-issue MIPS datapath. It sits directly upstream of the main control decoder. It owns the PC register and issues word requests to instruction memory over a req/valid handshake. It holds the fetched word in an output register whose `opcode` field drives the decoder, together with PC+4 for the PC-increment/branch/JAL path. Downstream back-pressure (`stall`) and control-flow redirects (branch taken, J, JAL, JR target from later logic) are handled through a PC FSM and a one-entry skid buffer.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded by reset; bits [1:0] must be 0
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  32  byte address of outstanding request, word aligned
- `imem_rdata`  in  32  instruction word, qualified by `imem_valid`
- `imem_valid`  in  1  response strobe, one cycle per request
- `stall`  in  1  decode not ready; output slot must hold
- `redirect`  in  1  one-cycle pulse: discard sequential stream, fetch from `redirect_pc`
- `redirect_pc`  in  32  new PC; bits [1:0] ignored (forced 0)
- `instr`  out  32  fetched instruction
- `opcode`  out  6  `instr[31:26]`, to control decoder
- `pc_plus4`  out  32  address of `instr` + 4
- `instr_valid`  out  1  output slot holds a live instruction

## Operation
- Registers: `pc` (next fetch address), `imem_addr`, output slot (`instr`, `pc_plus4`, `instr_valid`), skid buffer (word + addr + full flag), FSM state.
- Slot consumption: an instruction is taken by decode on any cycle with `instr_valid && !stall`.
- IDLE (reset state): `imem_req`=0. Next state is REQ, with `imem_addr`<=`pc`.
- REQ: `imem_req`=1 and `imem_addr` held stable until `imem_valid` is sampled.
  - On `imem_valid`, if the slot is free or being consumed: load slot with `imem_rdata` and `imem_addr`+4, `instr_valid`<=1, `pc`<=`pc`+4, `imem_addr`<=`pc`+4, stay REQ.
  - On `imem_valid` while the slot is full and `stall`=1: store the word in the skid buffer, `pc`<=`pc`+4, go to HOLD.
- HOLD: `imem_req`=0.
  - When the slot is consumed, move skid into the slot (`instr_valid` stays 1), `imem_addr`<=`pc`, go to REQ.
- DRAIN: `imem_req`=1 with the old `imem_addr`. The response is discarded on `imem_valid`, then `imem_addr`<=`pc`, go to REQ.
- Redirect has priority over everything, including `stall`:
  - Effects: `pc`<=`{redirect_pc[31:2],2'b00}`; `instr_valid`<=0; skid cleared.
  - In REQ without `imem_valid` that cycle: go to DRAIN, because the outstanding request cannot be withdrawn.
  - In REQ with `imem_valid` the same cycle: drop the response, `imem_addr`<=new pc, stay REQ.
  - In HOLD or IDLE: `imem_addr`<=new pc, go to REQ.
  - In DRAIN: update `pc` only and remain in DRAIN.
- Arithmetic: 32-bit PC, +4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
- `opcode` is always `instr[31:26]`. It is valid only when `instr_valid`=1.

## Timing
- Reset values (cycle after `rst` sampled high):
  - state IDLE, `imem_req`=0, `imem_addr`=`RESET_PC`, `pc`=`RESET_PC`
  - `instr`=0, `opcode`=0, `pc_plus4`=0, `instr_valid`=0, skid empty
- Reset asserted mid-request abandons the request; memory must tolerate `imem_req` dropping without a response.
- The first `imem_req` rises 1 cycle after `rst` deasserts.
- Memory contract: `imem_valid` arrives >= 1 cycle after the first cycle of `imem_req`, exactly once per request.
- Latency: `instr_valid` rises the cycle after `imem_valid` is sampled.
- Peak throughput: one instruction per 2 cycles with 1-cycle memory.
- HOLD exit: the skid entry appears in the slot the cycle after the consuming edge, and a new request is issued that same cycle.
- Redirect: `instr_valid`=0 on the cycle after the pulse.
  - From REQ or HOLD, the first new-target request is on the cycle after the pulse.
  - From DRAIN, it is the cycle after the stale `imem_valid`.
- Simultaneous `stall`=1 and `redirect`=1: redirect wins and the slot is flushed.

## Test plan
- Reset release with `RESET_PC`=0, 1-cycle memory -> `imem_addr` sequence 0,4,8. `instr_valid` first high at cycle 3, `pc_plus4`=4, `opcode` matches word[31:26] (e.g. 6'b100011 for lw).
- 3-wait-state memory -> `imem_req` and `imem_addr` stable for 4 cycles per fetch. No duplicate or missing words across 8 fetches.
- `stall` high for 5 cycles with a slot full and a response in flight -> skid captures the word and `imem_req`=0. After release, the words emerge in order with no loss.
- `redirect` to 32'h0000_0103 while a request to 0x10 is outstanding -> DRAIN. The 0x10 data is never presented, and the next `imem_addr`=32'h0000_0100.
- `redirect` coincident with `imem_valid` and `stall`=1 -> response dropped, `instr_valid`=0 next cycle, skid empty, fetch resumes at the target.
- `RESET_PC`=32'hFFFF_FFFC -> second fetch address 32'h0000_0000. `rst` pulsed mid-wait -> all outputs return to reset values.
